// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings,
// default operand width and small decode helpers.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  function automatic int mdu_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic mdu_is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// One iteration of the unsigned magnitude loop: shift-add for multiply,
// subtract-restore for divide, both on the 2*WIDTH accumulator.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    acc_o  = acc_i;
    if (is_div_i) begin
      if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      else              acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc_i[0]) acc_o = {sum, acc_i[WIDTH-1:1]};
      else          acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; fixed 33-edge latency.
// state  | meaning
// S_IDLE | accepts start, MTHI/MTLO
// S_CALC | WIDTH magnitude iterations
// S_FIX  | sign correction, HI/LO write, done pulse issued
// S_DONE | done visible; start ignored
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] sourceReg,
  input  logic [WIDTH-1:0] secondaryReg,
  input  logic             hiWrite,
  input  logic             loWrite,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = mdu_cnt_width(WIDTH);
  localparam int W2    = 2 * WIDTH;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q;
  logic             is_div_q, neg_res_q, neg_rem_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
  logic             done_q, dbz_out_q;

  mdu_op_e          op_e;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  assign op_e = mdu_op_e'(op);

  always_comb begin
    a_neg = mdu_is_signed(op_e) & sourceReg[WIDTH-1];
    b_neg = mdu_is_signed(op_e) & secondaryReg[WIDTH-1];
    a_mag = a_neg ? -sourceReg : sourceReg;
    b_mag = b_neg ? -secondaryReg : secondaryReg;
  end

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  // Divide by zero leaves the dividend magnitude in the remainder half, so the
  // normal remainder sign rule already reproduces rs; only LO needs forcing.
  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[W2-1:WIDTH];
    hi_d = prod[W2-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (is_div_q) begin
      lo_d = dbz_q ? '1 : (neg_res_q ? -quo : quo);
      hi_d = neg_rem_q ? -rem : rem;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hiWrite) hi_q <= sourceReg;
          if (loWrite) lo_q <= sourceReg;
          if (start) begin
            state_q   <= S_CALC;
            count_q   <= '0;
            is_div_q  <= mdu_is_div(op_e);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= mdu_is_div(op_e) && (secondaryReg == '0);
            if (mdu_is_div(op_e)) begin
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
              opnd_q <= a_mag;
            end
          end
        end
        S_CALC: begin
          acc_q   <= acc_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q      <= hi_d;
          lo_q      <= lo_d;
          done_q    <= 1'b1;
          dbz_out_q <= dbz_q;
          state_q   <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign divByZero = dbz_out_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        Clk;
  logic        Rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] sourceReg;
  logic [31:0] secondaryReg;
  logic        hiWrite;
  logic        loWrite;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .start        (start),
    .op           (op),
    .sourceReg    (sourceReg),
    .secondaryReg (secondaryReg),
    .hiWrite      (hiWrite),
    .loWrite      (loWrite),
    .busy         (busy),
    .done         (done),
    .divByZero    (divByZero),
    .hi           (hi),
    .lo           (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint      sa, sbv, p;
    logic [63:0] u;
    rz = 1'b0;
    rh = '0;
    rl = '0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sbv; {rh, rl} = p; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; {rh, rl} = u; end
      default: begin
        if (b == 32'h0) begin
          rh = a; rl = 32'hFFFF_FFFF; rz = 1'b1;
        end else if (o == 2'b10) begin
          rl = 32'(sa / sbv);
          rh = 32'(sa % sbv);
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(1'b0));
      end else begin
        e = sb.pop_front();
        chk("result_hi", 64'(hi), 64'(e.hi));
        chk("result_lo", 64'(lo), 64'(e.lo));
        chk("div_by_zero", 64'(divByZero), 64'(e.dbz));
        chk("latency", 64'(cyc - e.acc_cyc), 64'(33));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mt, input bit inject);
    exp_t        e;
    logic [31:0] rh, rl;
    logic        rz;
    int          bcnt;
    bit          got;
    ref_model(o, a, b, rh, rl, rz);
    start = 1'b1; op = o; sourceReg = a; secondaryReg = b;
    hiWrite = mt; loWrite = mt;
    if (mt) begin m_hi = a; m_lo = a; end
    @(posedge Clk); #1;
    e.hi = rh; e.lo = rl; e.dbz = rz; e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
    op = 2'($urandom); sourceReg = $urandom; secondaryReg = $urandom;
    bcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge Clk);
      if (busy) bcnt++;
      if (done) got = 1'b1;
      if (inject && i == 5) begin
        start = 1'b1; op = 2'b10; hiWrite = 1'b1; loWrite = 1'b1;
        sourceReg = 32'h1234; secondaryReg = 32'h1;
      end
      if (inject && i == 6) begin start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0; end
      if (i == 8) begin
        chk("hold_hi", 64'(hi), 64'(m_hi));
        chk("hold_lo", 64'(lo), 64'(m_lo));
      end
    end
    chk("done_seen", 64'(got), 64'(1'b1));
    chk("busy_cycles", 64'(bcnt), 64'(34));
    m_hi = rh;
    m_lo = rl;
    @(negedge Clk);
    chk("idle_after", 64'(busy), 64'(1'b0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; start = 1'b0; op = 2'b00;
    sourceReg = '0; secondaryReg = '0; hiWrite = 1'b0; loWrite = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dbz", 64'(divByZero), 64'(0));
    Rst_n = 1'b1;

    loWrite = 1'b1; sourceReg = 32'h0000_ABCD;
    @(negedge Clk);
    loWrite = 1'b0; m_lo = 32'h0000_ABCD;
    chk("mtlo_lo", 64'(lo), 64'(m_lo));
    chk("mtlo_hi", 64'(hi), 64'(m_hi));

    hiWrite = 1'b1; loWrite = 1'b1; sourceReg = 32'h1357_9BDF;
    @(negedge Clk);
    hiWrite = 1'b0; loWrite = 1'b0; m_hi = 32'h1357_9BDF; m_lo = 32'h1357_9BDF;
    chk("mthilo_hi", 64'(hi), 64'(m_hi));
    chk("mthilo_lo", 64'(lo), 64'(m_lo));

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 1'b0);
    run_op(2'b01, 32'd1000, 32'd77, 1'b0, 1'b1);
    run_op(2'b00, 32'h0000_DEAD, 32'h0000_0011, 1'b1, 1'b0);

    // Reset lands on E10 of an operation; nothing from it may survive.
    start = 1'b1; op = 2'b11; sourceReg = 32'd12345; secondaryReg = 32'd7;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    Rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge Clk);

    for (int k = 0; k < 40; k++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
